// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes a MIPS instruction into ALU operation/operands and
// holds them in a 2-entry skid buffer with valid/ready on both sides.
module alu_issue_stage #(
  parameter int DATA_W         = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [4:0]        ex_operation,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [4:0]        ex_shamt,
  output logic [4:0]        ex_dest,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [4:0]        operation;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [4:0]        shamt;
    logic [4:0]        dest;
    logic              reg_write;
    logic              illegal;
  } entry_t;

  state_t state, state_nxt;
  entry_t head, skid, dec;
  logic   bad;
  logic   head_load_dec, head_load_skid, skid_load;
  logic   take_in, take_out;

  logic [5:0]        opcode, fn;
  logic [DATA_W-1:0] imm_s, imm_z;
  logic              unused_rs_field;

  assign opcode          = id_instr[31:26];
  assign fn              = id_instr[5:0];
  assign imm_s           = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
  assign imm_z           = {{(DATA_W-16){1'b0}}, id_instr[15:0]};
  // Operand values arrive already forwarded; the rs index itself is not needed.
  assign unused_rs_field = ^id_instr[25:21];

  always_comb begin
    // NOTE: every field gets a default first so no path through the case infers a latch.
    dec = '0;
    bad = 1'b0;
    case (opcode)
      6'h00: begin
        dec.dest      = id_instr[15:11];
        dec.reg_write = 1'b1;
        dec.op1       = id_rs_val;
        dec.op2       = id_rt_val;
        case (fn)
          6'h20, 6'h21: dec.operation = 5'h3;
          6'h22, 6'h23: begin
            // Swapped so the ALU's Op2-Op1 yields rs-rt.
            dec.operation = 5'h5;
            dec.op1       = id_rt_val;
            dec.op2       = id_rs_val;
          end
          6'h24: dec.operation = 5'h4;
          6'h25: dec.operation = 5'h2;
          6'h27: dec.operation = 5'ha;
          6'h2a: dec.operation = 5'h8;
          6'h2b: dec.operation = 5'h9;
          6'h00, 6'h02: begin
            dec.operation = (fn == 6'h00) ? 5'h6 : 5'h7;
            dec.op1       = '0;
            dec.shamt     = id_instr[10:6];
          end
          6'h08: begin
            dec.operation = 5'hb;
            dec.op1       = '0;
            dec.op2       = id_rs_val;
            dec.reg_write = 1'b0;
          end
          default: bad = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23: begin
        dec.op1       = id_rs_val;
        dec.dest      = id_instr[20:16];
        dec.reg_write = 1'b1;
        dec.op2       = imm_s;
        case (opcode)
          6'h0a:   dec.operation = 5'h8;
          6'h0b:   dec.operation = 5'h9;
          6'h0c:   begin dec.operation = 5'h4; dec.op2 = imm_z; end
          6'h0d:   begin dec.operation = 5'h2; dec.op2 = imm_z; end
          6'h0f:   begin dec.operation = 5'h1; dec.op2 = imm_z; end
          default: dec.operation = 5'h3;
        endcase
      end
      6'h2b: begin
        dec.operation = 5'h3;
        dec.op1       = id_rs_val;
        dec.op2       = imm_s;
        dec.dest      = id_instr[20:16];
      end
      6'h04, 6'h05: begin
        // Subtract rs-rt so the ALU zero flag answers rs==rt.
        dec.operation = 5'h5;
        dec.op1       = id_rt_val;
        dec.op2       = id_rs_val;
        dec.dest      = id_instr[20:16];
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.illegal = ILLEGAL_AS_NOP;
    end
  end

  assign take_in  = id_valid && id_ready;
  assign take_out = ex_valid && ex_ready;

  always_comb begin
    state_nxt      = state;
    head_load_dec  = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      EMPTY: if (take_in) begin
        state_nxt     = ONE;
        head_load_dec = 1'b1;
      end
      ONE: begin
        if (take_in && !take_out) begin
          state_nxt = FULL;
          skid_load = 1'b1;
        end else if (take_out && !take_in) begin
          state_nxt = EMPTY;
        end else if (take_in && take_out) begin
          head_load_dec = 1'b1;
        end
      end
      FULL: if (take_out) begin
        state_nxt      = ONE;
        head_load_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush discards everything; data registers simply keep their stale value.
    if (flush) begin
      state_nxt      = EMPTY;
      head_load_dec  = 1'b0;
      head_load_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      id_ready <= 1'b1;
      ex_valid <= 1'b0;
      head     <= '0;
      skid     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      id_ready <= (state_nxt != FULL);
      ex_valid <= (state_nxt != EMPTY);
      if (head_load_dec)       head <= dec;
      else if (head_load_skid) head <= skid;
      if (skid_load)           skid <= dec;
    end
  end

  assign ex_operation = head.operation;
  assign ex_op1       = head.op1;
  assign ex_op2       = head.op2;
  assign ex_shamt     = head.shamt;
  assign ex_dest      = head.dest;
  assign ex_reg_write = head.reg_write;
  assign ex_illegal   = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, stall/skid ordering, flush, async reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, ex_ready;
  logic        id_ready, ex_valid;
  logic [31:0] id_instr, id_rs_val, id_rt_val;
  logic [4:0]  ex_operation, ex_shamt, ex_dest;
  logic [31:0] ex_op1, ex_op2;
  logic        ex_reg_write, ex_illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  // {operation, op1, op2, shamt, dest, reg_write, illegal}
  wire [80:0] ex_bus = {ex_operation, ex_op1, ex_op2, ex_shamt, ex_dest, ex_reg_write, ex_illegal};

  alu_issue_stage #(.DATA_W(32), .ILLEGAL_AS_NOP(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_operation(ex_operation), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_shamt(ex_shamt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  localparam int NV = 12;
  logic [31:0] v_instr [NV] = '{32'h00221820, 32'h00222022, 32'h10200003, 32'h2025FFFF,
                                32'h3426FFFF, 32'h00023900, 32'h3C088001, 32'h03E00008,
                                32'hAC200004, 32'h2829FFFE, 32'hFC000000, 32'h0022502A};
  logic [31:0] v_rs [NV] = '{32'd5, 32'd9, 32'd6, 32'd10, 32'h12340000, 32'd0,
                             32'd0, 32'h400, 32'h100, 32'd3, 32'h55, 32'd1};
  logic [31:0] v_rt [NV] = '{32'd7, 32'd4, 32'd6, 32'd0, 32'd0, 32'h81,
                             32'd0, 32'd0, 32'd0, 32'd0, 32'h66, 32'd2};
  logic [80:0] v_exp [NV] = '{
    {5'h3, 32'd5,         32'd7,         5'd0, 5'd3,  1'b1, 1'b0},  // add
    {5'h5, 32'd4,         32'd9,         5'd0, 5'd4,  1'b1, 1'b0},  // sub
    {5'h5, 32'd6,         32'd6,         5'd0, 5'd0,  1'b0, 1'b0},  // beq
    {5'h3, 32'd10,        32'hFFFFFFFF,  5'd0, 5'd5,  1'b1, 1'b0},  // addi
    {5'h2, 32'h12340000,  32'h0000FFFF,  5'd0, 5'd6,  1'b1, 1'b0},  // ori
    {5'h6, 32'd0,         32'h81,        5'd4, 5'd7,  1'b1, 1'b0},  // sll
    {5'h1, 32'd0,         32'h00008001,  5'd0, 5'd8,  1'b1, 1'b0},  // lui
    {5'hb, 32'd0,         32'h400,       5'd0, 5'd0,  1'b0, 1'b0},  // jr
    {5'h3, 32'h100,       32'd4,         5'd0, 5'd0,  1'b0, 1'b0},  // sw
    {5'h8, 32'd3,         32'hFFFFFFFE,  5'd0, 5'd9,  1'b1, 1'b0},  // slti
    {5'h0, 32'd0,         32'd0,         5'd0, 5'd0,  1'b0, 1'b1},  // opcode 0x3F
    {5'h8, 32'd1,         32'd2,         5'd0, 5'd10, 1'b1, 1'b0}   // slt
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_add(input logic [31:0] rs);
    id_valid  = 1'b1;
    id_instr  = 32'h00221820;
    id_rs_val = rs;
    id_rt_val = 32'd1;
  endtask

  function automatic logic [80:0] add_exp(input logic [31:0] rs);
    return {5'h3, rs, 32'd1, 5'd0, 5'd3, 1'b1, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
    id_instr = '0; id_rs_val = '0; id_rt_val = '0;
    #2;
    n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready: got %b want 1", id_ready); end
    n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    n_cmp++; if (ex_bus !== 81'd0) begin n_fail++; $display("FAIL reset_ex_bus: got %h want 0", ex_bus); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_decode();
    ex_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      id_valid  = 1'b1;
      id_instr  = v_instr[i];
      id_rs_val = v_rs[i];
      id_rt_val = v_rt[i];
      step();
      n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL decode_valid[%0d]: got %b want 1", i, ex_valid); end
      n_cmp++; if (ex_bus !== v_exp[i]) begin n_fail++; $display("FAIL decode[%0d] instr %h: got %h want %h", i, v_instr[i], ex_bus, v_exp[i]); end
    end
    id_valid = 1'b0;
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL decode_drain: ex_valid got %b want 0", ex_valid); end
  endtask

  task automatic test_back_to_back_stall();
    ex_ready = 1'b0;
    offer_add(32'h11);
    step();
    n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready1: got %b want 1", id_ready); end
    n_cmp++; if (ex_bus !== add_exp(32'h11)) begin n_fail++; $display("FAIL stall_head1: got %h want %h", ex_bus, add_exp(32'h11)); end
    offer_add(32'h22);
    step();
    n_cmp++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_ready: got %b want 0", id_ready); end
    n_cmp++; if (ex_bus !== add_exp(32'h11)) begin n_fail++; $display("FAIL stall_head2: got %h want %h", ex_bus, add_exp(32'h11)); end
    offer_add(32'h33);
    step();
    n_cmp++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_third_ready: got %b want 0", id_ready); end
    n_cmp++; if (ex_bus !== add_exp(32'h11)) begin n_fail++; $display("FAIL stall_hold: got %h want %h", ex_bus, add_exp(32'h11)); end
    ex_ready = 1'b1;
    step();
    n_cmp++; if (ex_bus !== add_exp(32'h22)) begin n_fail++; $display("FAIL release_b: got %h want %h", ex_bus, add_exp(32'h22)); end
    n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", id_ready); end
    step();
    n_cmp++; if (ex_bus !== add_exp(32'h33)) begin n_fail++; $display("FAIL release_c: got %h want %h", ex_bus, add_exp(32'h33)); end
    n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL release_c_valid: got %b want 1", ex_valid); end
    id_valid = 1'b0;
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL release_empty: got %b want 0", ex_valid); end
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    offer_add(32'h41);
    step();
    offer_add(32'h42);
    step();
    n_cmp++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prefull: got %b want 0", id_ready); end
    flush = 1'b1;
    offer_add(32'h43);
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid: got %b want 0", ex_valid); end
    n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_id_ready: got %b want 1", id_ready); end
    flush = 1'b0; id_valid = 1'b0;
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: ex_valid got %b want 0", ex_valid); end
    ex_ready = 1'b1;
    offer_add(32'h44);
    step();
    n_cmp++; if (ex_bus !== add_exp(32'h44)) begin n_fail++; $display("FAIL flush_resume: got %h want %h", ex_bus, add_exp(32'h44)); end
    id_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    ex_ready = 1'b0;
    offer_add(32'h77);
    step();
    id_valid = 1'b0;
    n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: ex_valid got %b want 1", ex_valid); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL areset_ex_valid: got %b want 0", ex_valid); end
    n_cmp++; if (ex_bus !== 81'd0) begin n_fail++; $display("FAIL areset_ex_bus: got %h want 0", ex_bus); end
    n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL areset_id_ready: got %b want 1", id_ready); end
    #1 rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back_stall();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
